ps2_mouse_rx: RTL and testbench

//  PS/2 mouse receiver: deserialises 11-bit device-to-host frames, assembles standard
//  3-byte movement packets, reports buttons/dX/dY and keeps a saturating 8-bit X position.
//  pos_x drives the 8-bit binary input of the binary-to-BCD converter (held stable

---
 rtl/ps2_mouse_rx_pkg.sv | 21 ++
 rtl/ps2_mouse_rx_frame.sv | 111 +++++++++++
 rtl/ps2_mouse_rx.sv | 123 ++++++++++++
 tb/tb_ps2_mouse_rx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_rx_pkg.sv
// Shared types and constants for the PS/2 mouse receiver.
package ps2_mouse_rx_pkg;

   localparam int unsigned PS2_DATA_BITS = 8;
   localparam int unsigned PS2_SYNC_BIT  = 3;

   typedef enum logic [1:0] {
      FRM_IDLE,
      FRM_DATA,
      FRM_PARITY,
      FRM_STOP
   } frame_state_e;

   typedef struct packed {
      logic [2:0] buttons;
      logic [8:0] dx;
      logic [8:0] dy;
      logic [1:0] ovf;
   } ps2_pkt_t;

endpackage

// File: rtl/ps2_mouse_rx_frame.sv
// PS/2 device-to-host frame deserialiser: line synchronisers, falling-edge detect,
// start/data/parity/stop FSM and inter-edge timeout. Strobes are combinational.
module ps2_mouse_rx_frame
   import ps2_mouse_rx_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 100_000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_data_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);

   localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [2:0]       LAST_BIT = 3'(PS2_DATA_BITS - 1);

   logic [2:0]       clk_sync_q;
   logic [1:0]       data_sync_q;
   frame_state_e     state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fall;
   logic             data_bit;

   // [0],[1] form the synchroniser; [2] holds the previous synchronised level
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
      end else begin
         clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
      end
   end

   assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
   assign data_bit = data_sync_q[1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= FRM_IDLE;
         bit_cnt_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         cnt_q     <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      par_q   <= par_d;
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      cnt_d        = cnt_q;
      byte_valid_o = 1'b0;
      frame_err_o  = 1'b0;
      if (fall) begin
         // an edge always beats a coincident timeout
         cnt_d = '0;
         case (state_q)
            FRM_IDLE: begin
               if (!data_bit) begin
                  state_d   = FRM_DATA;
                  bit_cnt_d = '0;
               end
            end
            FRM_DATA: begin
               shift_d   = {data_bit, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == LAST_BIT) state_d = FRM_PARITY;
            end
            FRM_PARITY: begin
               par_d   = data_bit;
               state_d = FRM_STOP;
            end
            FRM_STOP: begin
               state_d = FRM_IDLE;
               if (data_bit && (^{shift_q, par_q})) byte_valid_o = 1'b1;
               else                                 frame_err_o  = 1'b1;
            end
            default: state_d = FRM_IDLE;
         endcase
      end else if (state_q != FRM_IDLE) begin
         if (cnt_q == CNT_LAST) begin
            state_d     = FRM_IDLE;
            cnt_d       = '0;
            frame_err_o = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   assign byte_data_o = shift_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver top: assembles 3-byte movement packets from received bytes and
// keeps a saturating 8-bit X position.
module ps2_mouse_rx
   import ps2_mouse_rx_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned TIMEOUT_US = 2000,
   parameter logic [7:0]  POS_INIT   = 8'd0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   output logic              pkt_valid,
   output logic [2:0]        buttons,
   output logic signed [8:0] dx,
   output logic signed [8:0] dy,
   output logic [1:0]        ovf,
   output logic [7:0]        pos_x,
   output logic              frame_err
);

   localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;
   logic [1:0] idx_q, idx_d;
   logic [6:0] hdr_q, hdr_d;
   logic [7:0] xb_q, xb_d;
   ps2_pkt_t   pkt_q, pkt_d, new_pkt;
   logic [7:0] pos_q, pos_d;
   logic       pkt_valid_q, pkt_valid_d;
   logic       err_q, err_d;

   function automatic logic [7:0] sat_add(input logic [7:0] pos, input logic [8:0] delta);
      logic signed [9:0] sum;
      sum = $signed({2'b00, pos}) + $signed({delta[8], delta});
      if (sum < 10'sd0)        sat_add = 8'd0;
      else if (sum > 10'sd255) sat_add = 8'd255;
      else                     sat_add = sum[7:0];
   endfunction

   ps2_mouse_rx_frame #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_frame (
      .clk          (clk),
      .rstn         (rstn),
      .ps2_clk_i    (ps2_clk),
      .ps2_data_i   (ps2_data),
      .byte_data_o  (rx_byte),
      .byte_valid_o (rx_valid),
      .frame_err_o  (rx_err)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_q       <= '0;
         pkt_q       <= '0;
         pos_q       <= POS_INIT;
         pkt_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         pkt_q       <= pkt_d;
         pos_q       <= pos_d;
         pkt_valid_q <= pkt_valid_d;
         err_q       <= err_d;
      end
   end

   // header keeps only the bits that are reported (bit 3 is the sync marker)
   always_ff @(posedge clk) begin
      hdr_q <= hdr_d;
      xb_q  <= xb_d;
   end

   always_comb begin
      idx_d            = idx_q;
      hdr_d            = hdr_q;
      xb_d             = xb_q;
      pkt_d            = pkt_q;
      pos_d            = pos_q;
      pkt_valid_d      = 1'b0;
      err_d            = rx_err;
      new_pkt.buttons  = hdr_q[2:0];
      new_pkt.dx       = {hdr_q[3], xb_q};
      new_pkt.dy       = {hdr_q[4], rx_byte};
      new_pkt.ovf      = hdr_q[6:5];
      if (rx_err) begin
         idx_d = '0;
      end else if (rx_valid) begin
         case (idx_q)
            2'd0: begin
               if (rx_byte[PS2_SYNC_BIT]) begin
                  hdr_d = {rx_byte[7:4], rx_byte[2:0]};
                  idx_d = 2'd1;
               end
            end
            2'd1: begin
               xb_d  = rx_byte;
               idx_d = 2'd2;
            end
            2'd2: begin
               pkt_d       = new_pkt;
               pkt_valid_d = 1'b1;
               idx_d       = 2'd0;
               if (!new_pkt.ovf[0]) pos_d = sat_add(pos_q, new_pkt.dx);
            end
            default: idx_d = 2'd0;
         endcase
      end
   end

   assign pkt_valid = pkt_valid_q;
   assign buttons   = pkt_q.buttons;
   assign dx        = pkt_q.dx;
   assign dy        = pkt_q.dy;
   assign ovf       = pkt_q.ovf;
   assign pos_x     = pos_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Scoreboard bench for ps2_mouse_rx: serialises PS/2 frames, predicts packets and
// errors with an integer model, and a negedge monitor checks each DUT strobe.
module tb_ps2_mouse_rx;

   localparam int CLK_HZ     = 1_000_000;
   localparam int TIMEOUT_US = 100;
   localparam int TO_CYC     = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int HALF       = 8;
   localparam int LAT        = 3;

   logic              clk      = 1'b0;
   logic              rstn     = 1'b0;
   logic              ps2_clk  = 1'b1;
   logic              ps2_data = 1'b1;
   logic              pkt_valid;
   logic [2:0]        buttons;
   logic signed [8:0] dx;
   logic signed [8:0] dy;
   logic [1:0]        ovf;
   logic [7:0]        pos_x;
   logic              frame_err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int buttons;
      int dx;
      int dy;
      int ovf;
      int pos;
      int due;
   } pkt_exp_t;

   pkt_exp_t pq[$];
   int       eq[$];
   pkt_exp_t mon_e;
   int       mon_due;
   int       m_idx = 0;
   int       m_hdr = 0;
   int       m_xb  = 0;
   int       m_pos = 0;
   int       r;
   int       fc;
   logic [7:0] h;

   ps2_mouse_rx #(
      .CLK_HZ     (CLK_HZ),
      .TIMEOUT_US (TIMEOUT_US),
      .POS_INIT   (8'd0)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .pkt_valid (pkt_valid),
      .buttons   (buttons),
      .dx        (dx),
      .dy        (dy),
      .ovf       (ovf),
      .pos_x     (pos_x),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int clamp_pos(input int p);
      if (p < 0)   return 0;
      if (p > 255) return 255;
      return p;
   endfunction

   // Reference: a good byte advances the 3-byte packet, header needs bit 3 set
   task automatic model_byte(input int b, input int due);
      pkt_exp_t e;
      if (m_idx == 0) begin
         if ((b & 8) != 0) begin
            m_hdr = b;
            m_idx = 1;
         end
      end else if (m_idx == 1) begin
         m_xb  = b;
         m_idx = 2;
      end else begin
         e.buttons = m_hdr & 7;
         e.dx      = ((m_hdr & 16) != 0) ? m_xb - 256 : m_xb;
         e.dy      = ((m_hdr & 32) != 0) ? b - 256 : b;
         e.ovf     = (m_hdr >> 6) & 3;
         if ((m_hdr & 64) == 0) m_pos = clamp_pos(m_pos + e.dx);
         e.pos     = m_pos;
         e.due     = due;
         pq.push_back(e);
         m_idx = 0;
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ps2_edge(input logic v, output int fall_cyc);
      ps2_data = v;
      wait_clk(HALF);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      wait_clk(HALF);
      ps2_clk  = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      int   f;
      logic par;
      par = ~(^b) ^ bad_par;
      ps2_edge(1'b0, f);
      for (int i = 0; i < 8; i++) ps2_edge(b[i], f);
      ps2_edge(par, f);
      ps2_data = ~bad_stop;
      wait_clk(HALF);
      ps2_clk = 1'b0;
      if (bad_par || bad_stop) begin
         m_idx = 0;
         eq.push_back(cyc + LAT);
      end else begin
         model_byte(int'(b), cyc + LAT);
      end
      wait_clk(HALF);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_clk(4 * HALF);
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_byte(b0, 1'b0, 1'b0);
      send_byte(b1, 1'b0, 1'b0);
      send_byte(b2, 1'b0, 1'b0);
   endtask

   task automatic send_trunc(input logic [7:0] b, input int nbits);
      int f;
      ps2_edge(1'b0, f);
      for (int i = 0; i < nbits; i++) ps2_edge(b[i], f);
      m_idx = 0;
      eq.push_back(f + LAT + TO_CYC);
      ps2_data = 1'b1;
      wait_clk(TO_CYC + 20);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pkt_valid"}, int'(pkt_valid), 0);
      check({tag, "_buttons"},   int'(buttons),   0);
      check({tag, "_dx"},        int'(dx),        0);
      check({tag, "_dy"},        int'(dy),        0);
      check({tag, "_ovf"},       int'(ovf),       0);
      check({tag, "_pos_x"},     int'(pos_x),     0);
      check({tag, "_frame_err"}, int'(frame_err), 0);
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (pkt_valid) begin
            if (pq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pkt_unexpected: got pkt_valid=1 at cycle %0d expected none", cyc);
            end else begin
               mon_e = pq.pop_front();
               check("pkt_cycle",   cyc,          mon_e.due);
               check("pkt_buttons", int'(buttons), mon_e.buttons);
               check("pkt_dx",      int'(dx),      mon_e.dx);
               check("pkt_dy",      int'(dy),      mon_e.dy);
               check("pkt_ovf",     int'(ovf),     mon_e.ovf);
               check("pkt_pos_x",   int'(pos_x),   mon_e.pos);
            end
         end
         if (frame_err) begin
            if (eq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL err_unexpected: got frame_err=1 at cycle %0d expected none", cyc);
            end else begin
               mon_due = eq.pop_front();
               check("err_cycle", cyc, mon_due);
            end
         end
      end
   end

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: got no finish within 80000 cycles expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      wait_clk(3);
      check_reset_outputs("reset");
      rstn = 1'b1;
      wait_clk(4);

      // basic movement
      send_pkt(8'h08, 8'h05, 8'h00);
      check("t1_pos_x",   int'(pos_x),   5);
      check("t1_dx",      int'(dx),      5);
      check("t1_buttons", int'(buttons), 0);
      check("t1_dy",      int'(dy),      0);

      // clamp low
      send_pkt(8'h18, 8'hFE, 8'h00);
      check("t2_pos_pre", int'(pos_x), 3);
      send_pkt(8'h19, 8'hFB, 8'h00);
      check("t2_buttons", int'(buttons), 1);
      check("t2_dx",      int'(dx),      -5);
      check("t2_pos_x",   int'(pos_x),   0);

      // clamp high, then X overflow freezes position
      send_pkt(8'h08, 8'hFA, 8'h00);
      check("t3_pos_pre", int'(pos_x), 250);
      send_pkt(8'h08, 8'h0A, 8'h00);
      check("t3_dx",    int'(dx),    10);
      check("t3_pos_x", int'(pos_x), 255);
      send_pkt(8'h48, 8'h7F, 8'h00);
      check("t3_ovf_pos", int'(pos_x), 255);
      check("t3_ovf",     int'(ovf),   1);
      check("t3_ovf_dx",  int'(dx),    127);

      // parity error drops the partial packet, bad stop likewise
      send_pkt(8'h18, 8'hF6, 8'h00);
      check("t4_pos_pre", int'(pos_x), 245);
      send_byte(8'h08, 1'b0, 1'b0);
      send_byte(8'h05, 1'b1, 1'b0);
      send_pkt(8'h08, 8'h01, 8'h00);
      check("t4_pos_x", int'(pos_x), 246);
      send_byte(8'h08, 1'b0, 1'b0);
      send_byte(8'h07, 1'b0, 1'b1);

      // timeout in the middle of a frame
      send_byte(8'h08, 1'b0, 1'b0);
      send_trunc(8'h55, 4);
      send_pkt(8'h08, 8'h02, 8'h00);
      check("t5_pos_x", int'(pos_x), 248);

      // resync: non-header byte dropped silently
      send_byte(8'h00, 1'b0, 1'b0);
      send_pkt(8'h09, 8'h02, 8'h00);
      check("t6_buttons", int'(buttons), 1);
      check("t6_pos_x",   int'(pos_x),   250);

      // reset in the middle of a frame and of a packet
      send_byte(8'h08, 1'b0, 1'b0);
      ps2_edge(1'b0, fc);
      ps2_edge(1'b1, fc);
      ps2_edge(1'b0, fc);
      rstn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_clk(3);
      check("midrst_hold_valid", int'(pkt_valid), 0);
      m_idx = 0;
      m_pos = 0;
      rstn  = 1'b1;
      wait_clk(4);
      send_byte(8'h05, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_pkt(8'h08, 8'h03, 8'h00);
      check("midrst_pos_x", int'(pos_x), 3);

      // randomized traffic
      for (int n = 0; n < 24; n++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            send_byte(8'($urandom) & 8'hF7, 1'b0, 1'b0);
         end else if (r == 1) begin
            send_byte(8'($urandom), 1'b1, 1'b0);
         end else begin
            h    = 8'($urandom);
            h[3] = 1'b1;
            if ($urandom_range(0, 3) != 0) h[7:6] = 2'b00;
            send_byte(h, 1'b0, 1'b0);
            send_byte(8'($urandom), 1'b0, 1'b0);
            send_byte(8'($urandom), 1'b0, 1'b0);
         end
      end
      check("rand_pos_x", int'(pos_x), m_pos);

      wait_clk(20);
      check("pkt_queue_empty", pq.size(), 0);
      check("err_queue_empty", eq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
